// File: rtl/collision_pkg.sv
// Shared definitions for the snake-game collision detector: state encoding
// and the default apple hold length.
package collision_pkg;

    localparam int STATE_W            = 2;
    localparam int APPLE_HOLD_DEFAULT = 1;
    localparam int HOLD_W             = 8;

    typedef enum logic [STATE_W-1:0] {
        RUN   = 2'b00,
        APPLE = 2'b01,
        DEAD  = 2'b10
    } state_t;

endpackage

// File: rtl/collision_edge_det.sv
// Single-bit rising-edge detector with synchronous active-low reset.
// A level present on the first cycle after reset counts as a rising edge.
module collision_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic prev;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev <= 1'b0;
        end else begin
            prev <= d;
        end
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/collision.sv
// Pixel-rate collision detector: classifies snake-head overlaps into a
// registered RUN / APPLE / DEAD game-event state for the game controller.
module collision
    import collision_pkg::*;
#(
    parameter int APPLE_HOLD = APPLE_HOLD_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               red_border,
    input  logic               red_apple,
    input  logic               grn_snake_head,
    input  logic               grn_snake_body,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(APPLE_HOLD - 1);

    logic hit_wall;
    logic hit_self;
    logic hit_apple;
    logic apple_rise;

    state_t            state;
    state_t            state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;

    assign hit_wall  = grn_snake_head & red_border;
    assign hit_self  = grn_snake_head & grn_snake_body;
    assign hit_apple = grn_snake_head & red_apple;

    collision_edge_det u_apple_edge (
        .clk   (clk),
        .reset (reset),
        .d     (hit_apple),
        .rise  (apple_rise)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= RUN;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = RUN;
        hold_nxt  = '0;
        // Death is sticky and outranks any apple activity, including a hold.
        if (state == DEAD || hit_wall || hit_self) begin
            state_nxt = DEAD;
        end else begin
            case (state)
                RUN: begin
                    if (apple_rise) begin
                        state_nxt = APPLE;
                        hold_nxt  = HOLD_INIT;
                    end
                end
                APPLE: begin
                    if (hold_cnt != '0) begin
                        state_nxt = APPLE;
                        hold_nxt  = hold_cnt - 1'b1;
                    end
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_collision.sv
// Self-checking bench for collision: two instances (APPLE_HOLD 1 and 4) share
// stimulus and are compared against a cycle-window reference model.
module tb_collision;

    logic       clk = 1'b0;
    logic       reset;
    logic       red_border;
    logic       red_apple;
    logic       grn_snake_head;
    logic       grn_snake_body;
    logic [1:0] st1;
    logic [1:0] st4;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: each instance is DEAD (sticky) or APPLE for the edges
    // [event, event+hold), otherwise RUN; a new event needs a rise after the window.
    int         holds [2] = '{1, 4};
    bit         dead  [2];
    int         apple_end [2];
    bit         prev_ha;
    logic [1:0] exp_st [2];

    collision #(.APPLE_HOLD(1)) dut1 (
        .clk            (clk),
        .reset          (reset),
        .red_border     (red_border),
        .red_apple      (red_apple),
        .grn_snake_head (grn_snake_head),
        .grn_snake_body (grn_snake_body),
        .state_o        (st1)
    );

    collision #(.APPLE_HOLD(4)) dut4 (
        .clk            (clk),
        .reset          (reset),
        .red_border     (red_border),
        .red_apple      (red_apple),
        .grn_snake_head (grn_snake_head),
        .grn_snake_body (grn_snake_body),
        .state_o        (st4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b expected %b at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_update(input bit rst_n, input bit b, input bit a, input bit h, input bit s);
        bit death;
        bit ha;
        bit rise;
        death = h && (b || s);
        ha    = h && a;
        rise  = ha && !prev_ha;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                dead[k]      = 1'b0;
                apple_end[k] = 0;
                exp_st[k]    = 2'b00;
            end else if (dead[k] || death) begin
                dead[k]   = 1'b1;
                exp_st[k] = 2'b10;
            end else if (cyc < apple_end[k]) begin
                exp_st[k] = 2'b01;
            end else if (rise && cyc > apple_end[k]) begin
                apple_end[k] = cyc + holds[k];
                exp_st[k]    = 2'b01;
            end else begin
                exp_st[k] = 2'b00;
            end
        end
        prev_ha = rst_n ? ha : 1'b0;
    endtask

    task automatic step(input bit rst_n, input bit b, input bit a, input bit h, input bit s,
                        input string tag);
        reset          = rst_n;
        red_border     = b;
        red_apple      = a;
        grn_snake_head = h;
        grn_snake_body = s;
        @(posedge clk);
        cyc++;
        model_update(rst_n, b, a, h, s);
        #1;
        check({tag, "/hold1"}, st1, exp_st[0]);
        check({tag, "/hold4"}, st4, exp_st[1]);
        check({tag, "/no11"}, {1'b0, st1 == 2'b11 || st4 == 2'b11}, 2'b00);
    endtask

    initial begin
        reset          = 1'b0;
        red_border     = 1'b0;
        red_apple      = 1'b0;
        grn_snake_head = 1'b0;
        grn_snake_body = 1'b0;
        prev_ha        = 1'b0;
        for (int k = 0; k < 2; k++) begin
            dead[k]      = 1'b0;
            apple_end[k] = 0;
            exp_st[k]    = 2'b00;
        end
        #2;

        // Reset with every input high, then release with inputs low.
        step(0, 1, 1, 1, 1, "rst_all_hi");
        step(0, 1, 1, 1, 1, "rst_all_hi");
        check("rst_literal", st1, 2'b00);
        step(1, 0, 0, 0, 0, "rst_release");
        step(1, 0, 0, 0, 0, "rst_release");
        check("rst_idle_literal", st4, 2'b00);

        // Wall hit for one cycle: DEAD next cycle and sticky.
        step(1, 1, 0, 1, 0, "wall");
        check("wall_literal", st1, 2'b10);
        for (int i = 0; i < 55; i++) step(1, 0, 0, 0, 0, "wall_sticky");
        check("wall_sticky_literal", st4, 2'b10);
        step(0, 0, 0, 0, 0, "wall_reset");
        check("wall_reset_literal", st1, 2'b00);

        // Body without head is harmless; head on body kills.
        step(1, 0, 0, 0, 1, "body_only");
        check("body_only_literal", st1, 2'b00);
        step(1, 0, 0, 1, 1, "self");
        check("self_literal", st4, 2'b10);
        step(0, 0, 0, 0, 0, "self_reset");
        step(1, 1, 1, 0, 0, "red_no_head");
        step(1, 0, 0, 1, 0, "head_only");
        check("head_only_literal", st1, 2'b00);

        // Apple held three cycles, dropped one, reasserted.
        step(1, 0, 1, 1, 0, "apple_a");
        check("apple_a1_h1", st1, 2'b01);
        check("apple_a1_h4", st4, 2'b01);
        step(1, 0, 1, 1, 0, "apple_a");
        check("apple_a2_h1", st1, 2'b00);
        step(1, 0, 1, 1, 0, "apple_a");
        check("apple_a3_h4", st4, 2'b01);
        step(1, 0, 0, 1, 0, "apple_drop");
        check("apple_drop_h4", st4, 2'b01);
        step(1, 0, 1, 1, 0, "apple_b");
        check("apple_b_h1", st1, 2'b01);
        check("apple_b_h4_ignored", st4, 2'b00);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, "idle");

        // Hold of four interrupted by a border hit.
        step(1, 0, 1, 1, 0, "hold_start");
        step(1, 0, 0, 0, 0, "hold_mid");
        check("hold_mid_h4", st4, 2'b01);
        step(1, 1, 0, 1, 0, "hold_border");
        check("hold_border_h4", st4, 2'b10);
        step(0, 0, 0, 0, 0, "hold_reset");

        // Apple and border together: death wins.
        step(1, 1, 1, 1, 0, "simul");
        check("simul_h1", st1, 2'b10);
        check("simul_h4", st4, 2'b10);
        step(0, 0, 1, 1, 0, "simul_reset");
        // Apple overlap still present after reset counts as a fresh edge.
        step(1, 0, 1, 1, 0, "post_reset_apple");
        check("post_reset_apple_h1", st1, 2'b01);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 31) != 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 15) == 0),
                 "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/collision.md
Name: collision

Overview:
- Pixel-rate collision detector for the snake game.
- Each cycle it receives one-bit overlap flags for the pixel currently being drawn: red layer (border, apple) and green layer (snake head, snake body).
- It classifies head collisions into a 2-bit game-event state consumed by the game controller.
- It sits between the pixel/sprite generators and the game FSM.

Parameters:
- APPLE_HOLD, default 1: number of cycles state_o reports APPLE per apple-eat event (legal range 1..255).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 at a clk edge resets).
- red_border  input  1  current pixel belongs to the border.
- red_apple  input  1  current pixel belongs to the apple.
- grn_snake_head  input  1  current pixel belongs to the snake head.
- grn_snake_body  input  1  current pixel belongs to the snake body (excluding the head).
- state_o  output  2  registered game-event state.

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is synchronous and active-low.
  - Reset has priority over everything else.
  - Reset value: state_o = RUN (2'b00); hold counter = 0; apple edge register = 0.
- State encoding: RUN=2'b00, APPLE=2'b01, DEAD=2'b10. Code 2'b11 is never produced.
- Hits, evaluated combinationally from the inputs sampled at each edge:
  - hit_wall = grn_snake_head & red_border
  - hit_self = grn_snake_head & grn_snake_body
  - hit_apple = grn_snake_head & red_apple
- Latency: a hit sampled at edge N is visible on state_o after edge N (one-cycle registered latency). There is no combinational path from input to output.
- Transitions (non-reset edges):
  - DEAD: sticky; remains DEAD until reset regardless of inputs.
  - Any state with hit_wall | hit_self -> DEAD.
  - RUN with a hit_apple rising edge (hit_apple=1 and previous-cycle hit_apple=0) -> APPLE; hold counter loads APPLE_HOLD-1.
  - APPLE with counter>0 -> APPLE; counter decrements.
  - APPLE with counter==0 -> RUN.
  - Otherwise -> RUN.
- Simultaneous events:
  - Death has priority over apple. If the head touches both apple and border/body in the same cycle -> DEAD.
  - A death hit while in APPLE -> DEAD immediately; the hold is abandoned.
- Apple edge detection:
  - Continuous head/apple overlap over many cycles produces exactly one APPLE event.
  - A new event requires hit_apple to deassert for at least one cycle.
  - A rising edge that occurs while already in APPLE is ignored (no re-trigger, no extension).
- Inputs with no effect on state:
  - red_border, red_apple or grn_snake_body without grn_snake_head.
  - grn_snake_head alone.
- Reset mid-operation (in APPLE or DEAD) -> RUN at the next edge. The edge register clears, so an apple overlap still present after reset counts as a new rising edge on the first post-reset cycle.
- No X propagation: all registers are reset; the default next-state is RUN.

Decomposition:
- Package collision_pkg holds the state width (2), the state constants RUN/APPLE/DEAD, and the default APPLE_HOLD.
- Optional sub-module collision_edge_det: single-bit rising-edge detector with synchronous active-low reset, used for hit_apple.
- The rest is a single FSM plus hold counter in collision.

Test Plan:
- Reset: drive reset=0 for 2 cycles with all inputs high -> state_o=00 during and after reset; release with inputs low -> stays 00.
- Wall hit: head=1, border=1 for 1 cycle, then border=0 -> state_o=10 one cycle later and remains 10 for 50+ cycles; reset=0 -> 00.
- Self hit: head=1, body=1 -> 10. Body=1 with head=0 -> stays 00.
- Apple with APPLE_HOLD=1: head=1, apple=1 held 3 cycles -> state_o=01 for exactly 1 cycle, then 00 while apple stays high. Drop apple for 1 cycle and reassert -> a second 01 pulse.
- Apple with APPLE_HOLD=4: a single apple edge -> 01 for 4 cycles, then 00. A border hit during the hold -> 10 on the next cycle.
- Simultaneous: head=1, apple=1, border=1 in the same cycle -> 10, never 01. state_o never equals 11 across a randomized input run.
